// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state and
// the bundle of register-control strobes it drives.
package pipeline_ctrl_pkg;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic pc_redirect;
    logic redirect_capture;
    logic load_if_id;
    logic flush_if_id;
    logic load_id_ex;
    logic flush_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
  } pipe_ctrl_t;

  // Named actions; every decode rule maps onto one of these.
  localparam pipe_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_CAPTURE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: freezes, bubbles and redirects the PC and
// inter-stage registers, deferring a mispredict redirect past an in-flight fetch.
//
// state    | meaning
// PC_RUN   | normal operation, redirects happen in the mispredict cycle
// PC_DRAIN | target captured, waiting for the stale fetch to return
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mispredict,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             load_pc,
  output logic             pc_redirect,
  output logic             redirect_capture,
  output logic             load_if_id,
  output logic             flush_if_id,
  output logic             load_id_ex,
  output logic             flush_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             state_o
);

  pipe_ctrl_state_t state_q, state_d;
  pipe_ctrl_t       ctrl;
  logic             stall_inc, flush_inc;
  logic             dstall, fstall, luse;

  assign dstall = dmem_req & ~dmem_resp;
  assign fstall = imem_read & ~imem_resp;
  assign luse   = ex_is_load & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_NORMAL;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        if (dstall) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (ex_mispredict && fstall) begin
          ctrl      = CTRL_CAPTURE;
          flush_inc = 1'b1;
          state_d   = PC_DRAIN;
        end else if (ex_mispredict) begin
          ctrl      = CTRL_REDIRECT;
          flush_inc = 1'b1;
        end else if (fstall) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (luse) begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
        end
      end
      PC_DRAIN: begin
        // EX and ID hold only bubbles here, so mispredict and luse are ignored
        if (dstall) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (imem_resp) begin
          ctrl    = CTRL_REDIRECT;
          state_d = PC_RUN;
        end else begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
        end
      end
      default: state_d = PC_RUN;
    endcase
    if (rst) begin
      ctrl      = CTRL_FREEZE;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PC_RUN;
    else     state_q <= state_d;
  end

  assign load_pc          = ctrl.load_pc;
  assign pc_redirect      = ctrl.pc_redirect;
  assign redirect_capture = ctrl.redirect_capture;
  assign load_if_id       = ctrl.load_if_id;
  assign flush_if_id      = ctrl.flush_if_id;
  assign load_id_ex       = ctrl.load_id_ex;
  assign flush_id_ex      = ctrl.flush_id_ex;
  assign load_ex_mem      = ctrl.load_ex_mem;
  assign load_mem_wb      = ctrl.load_mem_wb;
  assign state_o          = (state_q == PC_DRAIN);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic against an
// action-level reference model; a 4-bit-counter copy exercises saturation.
module tb_pipeline_ctrl;

  logic clk, rst;
  logic imem_read, imem_resp, dmem_req, dmem_resp, ex_mispredict, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_uses_rs1, id_uses_rs2;

  logic load_pc, pc_redirect, redirect_capture, load_if_id, flush_if_id;
  logic load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb, state_o;
  logic [31:0] stall_cycles, flush_count;

  logic s_load_pc, s_pc_redirect, s_redirect_capture, s_load_if_id, s_flush_if_id;
  logic s_load_id_ex, s_flush_id_ex, s_load_ex_mem, s_load_mem_wb, s_state_o;
  logic [3:0] s_stall_cycles, s_flush_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_drain;
  int unsigned m_stall, m_flush, m_stall_s, m_flush_s;

  // {load_pc, pc_redirect, capture, load_if_id, flush_if_id, load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}
  localparam logic [8:0] A_NORMAL   = 9'b100101011;
  localparam logic [8:0] A_FREEZE   = 9'b000000000;
  localparam logic [8:0] A_REDIRECT = 9'b110111111;
  localparam logic [8:0] A_CAPTURE  = 9'b001111111;
  localparam logic [8:0] A_BUBBLE   = 9'b000001111;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .ex_mispredict(ex_mispredict),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .load_pc(load_pc), .pc_redirect(pc_redirect), .redirect_capture(redirect_capture),
    .load_if_id(load_if_id), .flush_if_id(flush_if_id), .load_id_ex(load_id_ex),
    .flush_id_ex(flush_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state_o(state_o)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .ex_mispredict(ex_mispredict),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .load_pc(s_load_pc), .pc_redirect(s_pc_redirect), .redirect_capture(s_redirect_capture),
    .load_if_id(s_load_if_id), .flush_if_id(s_flush_if_id), .load_id_ex(s_load_id_ex),
    .flush_id_ex(s_flush_id_ex), .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count), .state_o(s_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decide the cycle's action from the rule list, expressed as named actions.
  task automatic model(output logic [8:0] act, output bit nd, output bit si, output bit fi);
    bit dstall, fstall, luse;
    dstall = dmem_req && !dmem_resp;
    fstall = imem_read && !imem_resp;
    luse   = ex_is_load && ex_rd != 0 &&
             ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    nd = m_drain; si = 0; fi = 0; act = A_NORMAL;
    if (rst) begin
      act = A_FREEZE; nd = 0;
    end else if (dstall) begin
      act = A_FREEZE; si = 1;
    end else if (!m_drain) begin
      if (ex_mispredict && fstall) begin act = A_CAPTURE; fi = 1; nd = 1; end
      else if (ex_mispredict)      begin act = A_REDIRECT; fi = 1; end
      else if (fstall)             begin act = A_FREEZE; si = 1; end
      else if (luse)               begin act = A_BUBBLE; si = 1; end
    end else begin
      if (imem_resp) begin act = A_REDIRECT; nd = 0; end
      else           begin act = A_BUBBLE; si = 1; end
    end
  endtask

  task automatic step(input string tag);
    logic [8:0] act, obs, obs_s;
    bit nd, si, fi;
    #1;
    model(act, nd, si, fi);
    obs   = {load_pc, pc_redirect, redirect_capture, load_if_id, flush_if_id,
             load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb};
    obs_s = {s_load_pc, s_pc_redirect, s_redirect_capture, s_load_if_id, s_flush_if_id,
             s_load_id_ex, s_flush_id_ex, s_load_ex_mem, s_load_mem_wb};
    chk({tag, "_ctrl"}, 32'(obs), 32'(act));
    chk({tag, "_ctrl_s"}, 32'(obs_s), 32'(act));
    @(posedge clk);
    if (rst) begin
      m_drain = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      m_drain = nd;
      if (si) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_stall_s < 15) m_stall_s++;
      end
      if (fi) begin
        if (m_flush != 32'hFFFF_FFFF) m_flush++;
        if (m_flush_s < 15) m_flush_s++;
      end
    end
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'(m_drain));
    chk({tag, "_stall"}, stall_cycles, m_stall);
    chk({tag, "_flush"}, flush_count, m_flush);
    chk({tag, "_stall_s"}, 32'(s_stall_cycles), m_stall_s);
    chk({tag, "_flush_s"}, 32'(s_flush_count), m_flush_s);
    @(negedge clk);
  endtask

  task automatic idle();
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; ex_mispredict = 0;
    ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step("reset");
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    m_drain = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    step("por");
    rst = 0;

    // reset mid-DRAIN
    ex_mispredict = 1; imem_read = 1;
    step("t1_enter_drain");
    chk("t1_in_drain", 32'(state_o), 32'd1);
    ex_mispredict = 0;
    step("t1_drain");
    rst = 1;
    step("t1_rst");
    chk("t1_rst_state", 32'(state_o), 32'd0);
    chk("t1_rst_flush", flush_count, 32'd0);
    rst = 0;

    // load-use bubble, then rd=0 never stalls
    idle();
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    step("t2_luse");
    idle();
    step("t2_after");
    chk("t2_stall", stall_cycles, 32'd1);
    ex_is_load = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    step("t2_rd0");
    chk("t2_rd0_stall", stall_cycles, 32'd1);

    // dstall holds a mispredict for three cycles
    do_reset();
    dmem_req = 1; ex_mispredict = 1;
    repeat (3) step("t3_dstall");
    dmem_resp = 1;
    step("t3_redirect");
    chk("t3_flush", flush_count, 32'd1);
    chk("t3_stall", stall_cycles, 32'd3);

    // mispredict during in-flight fetch
    do_reset();
    ex_mispredict = 1; imem_read = 1;
    step("t4_capture");
    ex_mispredict = 0;
    step("t4_wait");
    imem_resp = 1;
    step("t4_resp");
    chk("t4_flush", flush_count, 32'd1);
    chk("t4_state", 32'(state_o), 32'd0);

    // mispredict coinciding with fetch return
    do_reset();
    ex_mispredict = 1; imem_read = 1; imem_resp = 1;
    step("t5_immediate");
    chk("t5_state", 32'(state_o), 32'd0);

    // saturation of the narrow counter
    do_reset();
    imem_read = 1;
    repeat (20) step("t6_fstall");
    chk("t6_sat", 32'(s_stall_cycles), 32'd15);
    chk("t6_wide", stall_cycles, 32'd20);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_resp     = ($urandom_range(0, 1) == 0);
      imem_read     = ($urandom_range(0, 1) == 0);
      imem_resp     = ($urandom_range(0, 2) == 0);
      ex_mispredict = ($urandom_range(0, 4) == 0);
      ex_is_load    = ($urandom_range(0, 1) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_uses_rs1   = ($urandom_range(0, 1) == 0);
      id_uses_rs2   = ($urandom_range(0, 1) == 0);
      step("rand");
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
